// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage registers: stage state encoding,
// per-boundary field widths and the ID/EX data packing layout.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } pipe_state_e;

  localparam int unsigned IFID_CTRL_W  = 1;
  localparam int unsigned IFID_DATA_W  = 96;
  localparam int unsigned IDEX_CTRL_W  = 12;
  localparam int unsigned IDEX_DATA_W  = 181;
  localparam int unsigned EXMEM_CTRL_W = 4;
  localparam int unsigned EXMEM_DATA_W = 101;
  localparam int unsigned MEMWB_CTRL_W = 3;
  localparam int unsigned MEMWB_DATA_W = 101;

  // ID/EX data layout (LSB offsets); bits [180:175] are reserved.
  localparam int unsigned IDEX_PCPLUS4_LSB = 0;
  localparam int unsigned IDEX_IMMEXT_LSB  = 32;
  localparam int unsigned IDEX_RD_LSB      = 64;
  localparam int unsigned IDEX_RS2_LSB     = 69;
  localparam int unsigned IDEX_RS1_LSB     = 74;
  localparam int unsigned IDEX_PC_LSB      = 79;
  localparam int unsigned IDEX_RD2_LSB     = 111;
  localparam int unsigned IDEX_RD1_LSB     = 143;

  // Flushing ID/EX keeps PCPlus4 so the bubble still carries the link address.
  localparam logic [IDEX_DATA_W-1:0] IDEX_KEEP_MASK =
    {{(IDEX_DATA_W-32){1'b0}}, {32{1'b1}}} << IDEX_PCPLUS4_LSB;

endpackage

// File: rtl/pipe_entry.sv
// One stage entry (ctrl, data, valid): load, clear with data-keep mask, drop, hold.
module pipe_entry import pipe_pkg::*; #(
  parameter int unsigned         CTRL_W    = IDEX_CTRL_W,
  parameter int unsigned         DATA_W    = IDEX_DATA_W,
  parameter logic [DATA_W-1:0]   KEEP_MASK = '0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic              drop_i,
  input  logic              clear_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o
);

  logic              valid_q, valid_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [DATA_W-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    data_d  = data_q;
    if (clear_i) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
      data_d  = data_i & KEEP_MASK;
    end else if (load_i) begin
      valid_d = 1'b1;
      ctrl_d  = ctrl_i;
      data_d  = data_i;
    end else if (drop_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign ctrl_o  = ctrl_q;
  assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Handshaked pipeline stage register with flush-to-bubble, optional skid entry
// and a saturating count of effective flushes.
module pipe_stage_reg import pipe_pkg::*; #(
  parameter int unsigned       CTRL_W    = IDEX_CTRL_W,
  parameter int unsigned       DATA_W    = IDEX_DATA_W,
  parameter logic [DATA_W-1:0] KEEP_MASK = '0,
  parameter int unsigned       SKID      = 1,
  parameter int unsigned       CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  flush_cnt
);

  pipe_state_e       state_q, state_d;
  logic              in_fire, out_fire;
  logic              main_load, main_drop, main_sel_skid;
  logic              skid_load, skid_drop;
  logic              skid_valid;
  logic [CTRL_W-1:0] skid_ctrl, main_ctrl_in;
  logic [DATA_W-1:0] skid_data, main_data_in;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_EMPTY;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: if (in_fire) state_d = ST_FULL;
        ST_FULL: begin
          if (out_fire && !in_fire)                    state_d = ST_EMPTY;
          else if (!out_fire && in_fire && SKID != 0)  state_d = ST_SKID;
        end
        ST_SKID:  if (out_fire) state_d = ST_FULL;
        default:  state_d = ST_EMPTY;
      endcase
    end
  end

  always_comb begin
    main_load     = 1'b0;
    main_drop     = 1'b0;
    main_sel_skid = 1'b0;
    skid_load     = 1'b0;
    skid_drop     = 1'b0;
    if (!flush) begin
      case (state_q)
        ST_EMPTY: main_load = in_fire;
        ST_FULL: begin
          main_load = in_fire & out_fire;
          main_drop = out_fire & ~in_fire;
          skid_load = in_fire & ~out_fire;
        end
        ST_SKID: begin
          main_load     = out_fire;
          main_sel_skid = 1'b1;
          skid_drop     = out_fire;
        end
        default: ;
      endcase
    end
  end

  // On flush main_sel_skid is low, so the keep mask is applied to in_data.
  assign main_ctrl_in = main_sel_skid ? skid_ctrl : in_ctrl;
  assign main_data_in = main_sel_skid ? skid_data : in_data;

  pipe_entry #(
    .CTRL_W    (CTRL_W),
    .DATA_W    (DATA_W),
    .KEEP_MASK (KEEP_MASK)
  ) u_main (
    .clk_i   (clk),
    .rst_i   (reset),
    .load_i  (main_load),
    .drop_i  (main_drop),
    .clear_i (flush),
    .ctrl_i  (main_ctrl_in),
    .data_i  (main_data_in),
    .valid_o (out_valid),
    .ctrl_o  (out_ctrl),
    .data_o  (out_data)
  );

  generate
    if (SKID != 0) begin : g_skid
      pipe_entry #(
        .CTRL_W    (CTRL_W),
        .DATA_W    (DATA_W),
        .KEEP_MASK ('0)
      ) u_skid (
        .clk_i   (clk),
        .rst_i   (reset),
        .load_i  (skid_load),
        .drop_i  (skid_drop),
        .clear_i (flush),
        .ctrl_i  (in_ctrl),
        .data_i  (in_data),
        .valid_o (skid_valid),
        .ctrl_o  (skid_ctrl),
        .data_o  (skid_data)
      );
      assign in_ready = ~skid_valid;
    end else begin : g_noskid
      logic skid_unused;
      assign skid_unused = skid_load | skid_drop;
      assign skid_valid  = 1'b0;
      assign skid_ctrl   = '0;
      assign skid_data   = '0;
      assign in_ready    = ~out_valid | out_ready;
    end
  endgenerate

  always_comb begin
    flush_cnt_d = flush_cnt_q;
    if (flush && (out_valid || skid_valid || in_valid) && flush_cnt_q != '1)
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) flush_cnt_q <= '0;
    else       flush_cnt_q <= flush_cnt_d;
  end

  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: a skid ID/EX instance and a no-skid instance.
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  localparam int unsigned CW = IDEX_CTRL_W;
  localparam int unsigned DW = IDEX_DATA_W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          a_reset, a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [CW-1:0] a_in_ctrl, a_out_ctrl;
  logic [DW-1:0] a_in_data, a_out_data;
  logic [15:0]   a_flush_cnt;

  logic          b_reset, b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [CW-1:0] b_in_ctrl, b_out_ctrl;
  logic [DW-1:0] b_in_data, b_out_data;
  logic [15:0]   b_flush_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  pipe_stage_reg #(
    .CTRL_W (CW), .DATA_W (DW), .KEEP_MASK (IDEX_KEEP_MASK), .SKID (1), .CNT_W (16)
  ) dut_skid (
    .clk (clk), .reset (a_reset), .flush (a_flush),
    .in_valid (a_in_valid), .in_ready (a_in_ready), .in_ctrl (a_in_ctrl), .in_data (a_in_data),
    .out_valid (a_out_valid), .out_ready (a_out_ready), .out_ctrl (a_out_ctrl),
    .out_data (a_out_data), .flush_cnt (a_flush_cnt)
  );

  pipe_stage_reg #(
    .CTRL_W (CW), .DATA_W (DW), .SKID (0), .CNT_W (16)
  ) dut_noskid (
    .clk (clk), .reset (b_reset), .flush (b_flush),
    .in_valid (b_in_valid), .in_ready (b_in_ready), .in_ctrl (b_in_ctrl), .in_data (b_in_data),
    .out_valid (b_out_valid), .out_ready (b_out_ready), .out_ctrl (b_out_ctrl),
    .out_data (b_out_data), .flush_cnt (b_flush_cnt)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic v, input logic [CW-1:0] c);
    a_in_valid = v;
    a_in_ctrl  = c;
    a_in_data  = '0;
    a_in_data[31:0] = 32'hD000_0000 | {20'h0, c};
  endtask

  task automatic drive_b(input logic v, input logic [CW-1:0] c);
    b_in_valid = v;
    b_in_ctrl  = c;
    b_in_data  = '0;
    b_in_data[31:0] = 32'hB000_0000 | {20'h0, c};
  endtask

  initial begin
    a_reset = 1'b1; a_flush = 1'b0; a_out_ready = 1'b1; drive_a(1'b0, '0);
    b_reset = 1'b1; b_flush = 1'b0; b_out_ready = 1'b1; drive_b(1'b0, '0);
    tick();
    check("a_rst_valid", 64'(a_out_valid), 0);
    check("a_rst_ctrl",  64'(a_out_ctrl), 0);
    check("a_rst_data",  64'(|a_out_data), 0);
    check("a_rst_cnt",   64'(a_flush_cnt), 0);
    check("a_rst_ready", 64'(a_in_ready), 1);
    check("b_rst_valid", 64'(b_out_valid), 0);
    a_reset = 1'b0; b_reset = 1'b0;

    // back-to-back flow, 1 entry per cycle
    for (int i = 1; i <= 3; i++) begin
      drive_a(1'b1, CW'(i));
      tick();
      check("a_b2b_valid", 64'(a_out_valid), 1);
      check("a_b2b_ctrl",  64'(a_out_ctrl), 64'(i));
      check("a_b2b_data",  64'(a_out_data[31:0]), 64'(32'hD000_0000 + i));
      check("a_b2b_ready", 64'(a_in_ready), 1);
    end
    drive_a(1'b0, '0);
    tick();
    check("a_drain_valid", 64'(a_out_valid), 0);
    check("a_drain_hold",  64'(a_out_ctrl), 3);

    // stall: 5 held in main, 6 captured in skid, 7 refused
    a_out_ready = 1'b0;
    drive_a(1'b1, 12'h5);
    tick();
    check("a_stall_ctrl5", 64'(a_out_ctrl), 5);
    check("a_stall_rdy1",  64'(a_in_ready), 1);
    drive_a(1'b1, 12'h6);
    tick();
    check("a_skid_ctrl5", 64'(a_out_ctrl), 5);
    check("a_skid_ready", 64'(a_in_ready), 0);
    drive_a(1'b1, 12'h7);
    tick();
    check("a_skid_hold",  64'(a_out_ctrl), 5);
    check("a_skid_hrdy",  64'(a_in_ready), 0);
    drive_a(1'b0, '0);
    a_out_ready = 1'b1;
    tick();
    check("a_unstall_v",  64'(a_out_valid), 1);
    check("a_unstall_c6", 64'(a_out_ctrl), 6);
    check("a_unstall_d6", 64'(a_out_data[31:0]), 64'(32'hD000_0006));
    check("a_unstall_rdy", 64'(a_in_ready), 1);
    tick();
    check("a_unstall_empty", 64'(a_out_valid), 0);

    // flush in SKID state with out_ready low
    a_out_ready = 1'b0;
    drive_a(1'b1, 12'h8);
    tick();
    drive_a(1'b1, 12'h9);
    tick();
    check("a_pre_flush_rdy", 64'(a_in_ready), 0);
    check("a_pre_flush_cnt", 64'(a_flush_cnt), 0);
    a_flush = 1'b1;
    a_in_valid = 1'b1;
    a_in_ctrl  = 12'hF;
    a_in_data  = '1;
    a_in_data[31:0] = 32'h104;
    tick();
    check("a_flush_valid", 64'(a_out_valid), 0);
    check("a_flush_ctrl",  64'(a_out_ctrl), 0);
    check("a_flush_keep",  64'(a_out_data[31:0]), 64'h104);
    check("a_flush_zero",  64'(|a_out_data[DW-1:32]), 0);
    check("a_flush_cnt",   64'(a_flush_cnt), 1);
    check("a_flush_ready", 64'(a_in_ready), 1);
    a_flush = 1'b0;
    a_out_ready = 1'b1;
    drive_a(1'b1, 12'hA);
    tick();
    check("a_post_flush_v", 64'(a_out_valid), 1);
    check("a_post_flush_c", 64'(a_out_ctrl), 64'hA);
    drive_a(1'b0, '0);
    tick();
    check("a_post_flush_e", 64'(a_out_valid), 0);

    // idle flush leaves the counter; a flush with only in_valid counts
    a_flush = 1'b1;
    tick();
    check("a_idle_flush_cnt", 64'(a_flush_cnt), 1);
    a_in_valid = 1'b1;
    tick();
    check("a_inv_flush_cnt", 64'(a_flush_cnt), 2);
    for (int i = 0; i < 65533; i++) tick();
    check("a_cnt_max", 64'(a_flush_cnt), 64'hFFFF);
    tick();
    check("a_cnt_sat", 64'(a_flush_cnt), 64'hFFFF);

    // reset mid-stall in SKID state; reset outranks a simultaneous flush
    a_flush = 1'b0;
    a_out_ready = 1'b0;
    drive_a(1'b1, 12'h11);
    tick();
    drive_a(1'b1, 12'h12);
    tick();
    check("a_rst2_pre_rdy", 64'(a_in_ready), 0);
    a_reset = 1'b1;
    a_flush = 1'b1;
    tick();
    check("a_rst2_valid", 64'(a_out_valid), 0);
    check("a_rst2_ctrl",  64'(a_out_ctrl), 0);
    check("a_rst2_data",  64'(|a_out_data), 0);
    check("a_rst2_cnt",   64'(a_flush_cnt), 0);
    check("a_rst2_ready", 64'(a_in_ready), 1);
    a_reset = 1'b0; a_flush = 1'b0; a_out_ready = 1'b1;
    drive_a(1'b0, '0);
    tick();
    check("a_rst2_empty", 64'(a_out_valid), 0);

    // no-skid variant: combinational in_ready and seamless stream
    drive_b(1'b1, 12'h21);
    tick();
    check("b_full_valid", 64'(b_out_valid), 1);
    check("b_full_ctrl",  64'(b_out_ctrl), 64'h21);
    b_out_ready = 1'b0;
    #1;
    check("b_stall_rdy", 64'(b_in_ready), 0);
    b_out_ready = 1'b1;
    #1;
    check("b_go_rdy", 64'(b_in_ready), 1);
    for (int i = 2; i <= 3; i++) begin
      drive_b(1'b1, CW'(12'h20 + i));
      tick();
      check("b_stream_valid", 64'(b_out_valid), 1);
      check("b_stream_ctrl",  64'(b_out_ctrl), 64'(32'h20 + i));
      check("b_stream_data",  64'(b_out_data[31:0]), 64'(32'hB000_0020 + i));
    end
    b_out_ready = 1'b0;
    drive_b(1'b1, 12'h24);
    tick();
    check("b_stall_hold", 64'(b_out_ctrl), 64'h23);
    check("b_stall_v",    64'(b_out_valid), 1);
    b_flush = 1'b1;
    b_in_data = '1;
    tick();
    check("b_flush_valid", 64'(b_out_valid), 0);
    check("b_flush_data",  64'(|b_out_data), 0);
    check("b_flush_cnt",   64'(b_flush_cnt), 1);
    check("b_flush_ready", 64'(b_in_ready), 1);
    b_flush = 1'b0;
    drive_b(1'b0, '0);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised, handshaked pipeline register for the pipelined RISC-V core. It generalises the fixed decode/execute register into one reusable stage with configurable control/data widths, valid/ready flow control (stall), flush-to-bubble with selectively preserved data fields, an optional skid entry that registers `in_ready`, and a saturating flush counter. It is instantiated between any two pipeline stages: IF/ID, ID/EX, EX/MEM or MEM/WB.

## Interface
- `CTRL_W`, default 12: control-field width (RegWrite, ResultSrc, MemWrite, Jump, Branch, ALUControl, ALUSrc, …).
- `DATA_W`, default 181: data-field width (RD1, RD2, PC, Rs1, Rs2, Rd, ImmExt, PCPlus4 packed).
- `KEEP_MASK`, default `{DATA_W{1'b0}}`: data bits loaded from `in_data` on flush; all other data bits are zeroed.
- `SKID`, default 1: 1 selects a two-entry stage with registered `in_ready`; 0 selects a single entry with combinational `in_ready`.
- `CNT_W`, default 16: flush-counter width.

Ports:
- `clk`, in, 1: the single clock; all state updates on the rising edge.
- `reset`, in, 1: synchronous, active-high.
- `flush`, in, 1: squash the stage contents and the current input.
- `in_valid`, in, 1: upstream entry valid.
- `in_ready`, out, 1: stage can accept an entry.
- `in_ctrl`, in, `CTRL_W`: upstream control field.
- `in_data`, in, `DATA_W`: upstream data field.
- `out_valid`, out, 1: output entry valid.
- `out_ready`, in, 1: downstream accepts (low means stall).
- `out_ctrl`, out, `CTRL_W`: registered control field.
- `out_data`, out, `DATA_W`: registered data field.
- `flush_cnt`, out, `CNT_W`: number of effective flushes, saturating.

## Operation
- Definitions:
  - `in_fire = in_valid & in_ready`
  - `out_fire = out_valid & out_ready`
- Storage: a main entry drives the outputs. When `SKID=1` there is also a skid entry (ctrl, data, valid).
- States:
  - EMPTY: main invalid.
  - FULL: main valid, skid empty.
  - SKID: main and skid both valid. Exists only when `SKID=1`.
- Transitions, with no flush:
  - EMPTY, on `in_fire`: go to FULL and load main.
  - FULL, with `out_fire` and `in_fire`: stay FULL and load main from input.
  - FULL, with `out_fire` only: go to EMPTY.
  - FULL, with `in_fire` only: go to SKID and load skid. This case only occurs when `SKID=1`.
  - SKID, on `out_fire`: go to FULL and move skid into main. No input is accepted in SKID.
- `in_ready`:
  - `SKID=1`: `in_ready = ~skid_valid`, taken directly from a register.
  - `SKID=0`: `in_ready = ~out_valid | out_ready`.
- Flush has priority over every transition. It applies from any state, next state is EMPTY, and the current input is dropped regardless of `in_fire`.
  - Main entry: valid cleared, `out_ctrl` cleared to 0, `out_data` set to `in_data & KEEP_MASK`.
  - Skid entry: cleared.
- `flush_cnt` increments on a flush cycle only if at least one of `out_valid`, `skid_valid` or `in_valid` is 1. It holds at all-ones.
- When the outputs are invalid (and no flush occurred), `out_ctrl`/`out_data` keep their last values. Consumers must qualify on `out_valid`.
- A flush while `out_ready=0` still empties the stage. No entry survives.

## Timing
- Latency: an accepted input appears on `out_*` with `out_valid=1` on the next cycle.
- Throughput: 1 entry per cycle while `out_ready=1`.
- Stall propagation:
  - `SKID=1`: `in_ready` falls one cycle after the first stalled accept.
  - `SKID=0`: `in_ready` falls combinationally in the same cycle.
- Reset values, visible the cycle after reset is sampled high:
  - `out_valid=0`, `out_ctrl=0`, `out_data=0`, skid cleared, `flush_cnt=0`, state EMPTY.
  - `in_ready=1`; when `SKID=0` it follows its combinational equation.
- Reset takes priority over flush. A reset asserted mid-stream discards all entries.
- Order preservation: the skid entry is always older than any subsequently accepted input. Entries are never reordered or duplicated.

## Structure
- Shared package `pipe_pkg`:
  - State enum (EMPTY/FULL/SKID).
  - `CTRL_W`/`DATA_W` defaults per stage boundary.
  - Localparam bit offsets for packing the decode/execute fields into `in_data`, plus the ID/EX `KEEP_MASK` that preserves the PCPlus4 slice.
- One sub-module, `pipe_entry`: a register of ctrl, data and valid with load, clear-with-mask and hold. Instantiated once for main and, when `SKID=1`, once for skid via generate.
- `flush_cnt` stays in the top module.

## Test plan
- Back-to-back flow, `SKID=1`, `out_ready=1`:
  - Stimulus: ctrl values 1, 2, 3 on consecutive cycles.
  - Response: `out_ctrl` = 1, 2, 3 one cycle later; `in_ready` stays 1.
- Stall with skid:
  - Stimulus: `out_ready=0` while ctrl 5 then 6 are offered.
  - Response: 5 held on the output; 6 captured in skid; `in_ready=0` next cycle. On releasing `out_ready`, 5 then 6 appear in order with no loss.
- Flush in SKID state:
  - Setup: `KEEP_MASK` covers bits [31:0]; `in_data[31:0]=0x104`.
  - Response: next cycle `out_valid=0`, `out_ctrl=0`, `out_data[31:0]=0x104`, other bits 0; `flush_cnt` 0→1; stage accepts again.
- Idle flush:
  - Stimulus: flush while all of `out_valid`, `skid_valid` and `in_valid` are 0.
  - Response: `flush_cnt` unchanged.
- `SKID=0` variant:
  - Stimulus: stage full, `out_ready=0`.
  - Response: `in_ready=0` the same cycle. With `out_ready=1`, a simultaneous accept gives a seamless 1/cycle stream.
- Reset mid-stall:
  - Stimulus: `reset=1` for 1 cycle while in SKID state with `flush_cnt=0xFFFF` (saturation checked beforehand).
  - Response: next cycle all outputs at reset values, `flush_cnt=0`.
